// File: rtl/serial_alu.sv
// serial_alu: bit-serial ALU, one operand bit per clock through a single slice with a registered carry
module serial_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-2:0] r_res_sr;
  logic [2:0]       r_sel;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_bop, w_arith, w_bit, w_cout, w_last, w_accept;
  logic [WIDTH-1:0] w_full;
  assign busy = (r_state == RUN);
  always_comb begin
    w_accept = (r_state == IDLE) && start;
    w_last   = (r_cnt == CW'(WIDTH - 1));
    w_arith  = (r_sel[2:1] == 2'b01);
    w_bop    = r_sel[0] ? ~r_b[0] : r_b[0];
    w_bit    = (r_sel == 3'b000) ? r_b[0] :
               w_arith           ? r_a[0] ^ w_bop ^ r_carry :
               (r_sel == 3'b100) ? r_a[0] & r_b[0] :
               (r_sel == 3'b101) ? r_a[0] | r_b[0] :
               (r_sel == 3'b110) ? r_a[0] ^ r_b[0] : 1'b0;
    w_cout   = w_arith & ((r_a[0] & w_bop) | (r_carry & (r_a[0] ^ w_bop)));
    w_full   = {w_bit, r_res_sr};
    w_next   = (r_state == IDLE) ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // Result bits enter at the MSB so the value is fully aligned after WIDTH shifts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= '0;
      r_res_sr  <= '0;
      r_sel     <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      done      <= 1'b0;
      result    <= '0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_sel   <= sel;
        r_carry <= (sel == 3'b011);
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_res_sr <= w_full[WIDTH-1:1];
        r_carry  <= w_cout;
        r_cnt    <= r_cnt + CW'(1);
        if (w_last) begin
          result    <= w_full;
          negative  <= w_bit;
          zero      <= (w_full == '0);
          carry_out <= w_cout;
          overflow  <= w_arith & (r_carry ^ w_cout);
          done      <= 1'b1;
        end
      end
    end
  end
endmodule
